// File: rtl/pixel_framebuf.sv
// pixel_framebuf: double-buffered pixel store; bytes are written into the back bank, whole pixels are read from the front bank
// Ports:
//   clk, rst_n                  single clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_din      byte write into the back bank (addresses past the last pixel are dropped)
//   rd_req, rd_px, rd_ready     pixel read request, pixel index, request can be accepted
//   rd_valid, rd_dout, rd_err   one-cycle result pulse, held assembled pixel, index-out-of-range flag
//   swap_req, swap_ack          bank exchange request, one-cycle pulse once the exchange has happened
//   bank_sel                    index of the current front (read) bank
module pixel_framebuf #(
    parameter int DATA     = 8,
    parameter int BYTES_PX = 3,
    parameter int NUM_PX   = 256,
    parameter int ADDR     = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR-1:0]          wr_addr,
    input  logic [DATA-1:0]          wr_din,
    input  logic                     rd_req,
    input  logic [7:0]               rd_px,
    output logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA*BYTES_PX-1:0] rd_dout,
    output logic                     rd_err,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     bank_sel
);
    localparam int W   = DATA * BYTES_PX;
    localparam int LIM = NUM_PX * BYTES_PX;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t            state, nxt;
    logic              swap_pending;
    logic [1:0]        cnt;
    logic [ADDR-1:0]   base;
    logic [ADDR-1:0]   rd_addr;
    logic              err;
    logic [W-1:0]      sh;
    logic [DATA-1:0]   rd_byte;
    logic              accept;
    logic              do_swap;
    logic [DATA-1:0]   mem [2**(ADDR+1)];

    assign rd_ready = (state == IDLE) && !swap_pending;
    // a swap request arriving together with a read request wins the cycle
    assign accept   = rd_req && rd_ready && !swap_req;
    // DONE never reads memory and always returns to IDLE, so the exchange can ride that edge
    assign do_swap  = swap_pending && (state == IDLE || state == DONE);
    assign rd_addr  = base + ADDR'(cnt);
    assign rd_byte  = mem[{bank_sel, rd_addr}];

    always_comb begin
        nxt = state;
        nxt = (state == IDLE)  ? (accept ? FETCH : IDLE) :
              (state == FETCH) ? ((cnt == 2'(BYTES_PX - 1)) ? DONE : FETCH) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bank_sel     <= 1'b0;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
            rd_valid     <= 1'b0;
            rd_err       <= 1'b0;
            rd_dout      <= '0;
            cnt          <= '0;
            base         <= '0;
            err          <= 1'b0;
            sh           <= '0;
        end else begin
            state        <= nxt;
            swap_ack     <= do_swap;
            swap_pending <= do_swap ? 1'b0 : (swap_pending | swap_req);
            rd_valid     <= (state == DONE);
            if (do_swap)
                bank_sel <= ~bank_sel;
            if (accept) begin
                cnt  <= '0;
                base <= ADDR'(rd_px) * ADDR'(BYTES_PX);
                err  <= (32'(rd_px) >= NUM_PX);
            end
            // first byte fetched ends up in the MSBs after BYTES_PX shifts
            if (state == FETCH) begin
                sh  <= (sh << DATA) | W'(rd_byte);
                cnt <= cnt + 2'd1;
            end
            if (state == DONE) begin
                rd_dout <= err ? '0 : sh;
                rd_err  <= err;
            end
        end
    end

    // storage is deliberately outside the reset domain so contents survive a reset
    always_ff @(posedge clk)
        if (wr_en && 32'(wr_addr) < LIM)
            mem[{~bank_sel, wr_addr}] <= wr_din;
endmodule
